// File: rtl/slv_arbiter_rr.sv
// slv_arbiter_rr: merges NUM_SLV slave streams onto one FIFO write port using round-robin grants
// with bounded bursts, FIFO back-pressure and a master-complete halt. Option macro: ARB_URGENT_EN.
module slv_arbiter_rr #(
  parameter int NUM_SLV   = 4,
  parameter int DW        = 32,
  parameter int PV_W      = 8,
  parameter int MODE_W    = 2,
  parameter int BURST_MAX = 16,
  localparam int SW       = $clog2(NUM_SLV)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SLV-1:0][MODE_W-1:0] slv_mode,
  input  logic [NUM_SLV-1:0]             slv_data_valid,
  input  logic [NUM_SLV-1:0][DW-1:0]     slv_data,
  input  logic [NUM_SLV-1:0][PV_W-1:0]   slv_proc_val,
  output logic [NUM_SLV-1:0]             slv_ready,
  input  logic                           fifo_full,
  input  logic                           mstr_cmplt,
  output logic [DW-1:0]                  slvx_data,
  output logic                           slvx_data_valid,
  output logic [MODE_W-1:0]              slvx_mode,
  output logic [PV_W-1:0]                slvx_proc_val,
  output logic [SW-1:0]                  data_source
);

  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, HALT} st_e;

  st_e                       state, state_nxt;
  logic [SW-1:0]             ptr, ptr_nxt, grant, grant_nxt, grant_inc, pick;
  logic [BW-1:0]             bcnt, bcnt_nxt;
  logic [NUM_SLV-1:0]        req, xfer_v;
  logic [NUM_SLV-1:0][SW-1:0] rr_idx;
  logic                      busy, gate, xfer, burst_end, pick_vld;

  assign gate = busy & ~fifo_full & ~mstr_cmplt;
  assign xfer = |xfer_v;

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_lane
    assign req[i]       = |slv_mode[i];
    assign slv_ready[i] = gate & req[i] & (grant == SW'(i));
    assign xfer_v[i]    = slv_ready[i] & slv_data_valid[i];
  end

  // rr_idx[k] = (ptr + k) mod NUM_SLV, valid for non-power-of-two NUM_SLV too
  for (genvar k = 0; k < NUM_SLV; k++) begin : g_rr
    logic [SW:0] sum;
    assign sum       = {1'b0, ptr} + (SW+1)'(k);
    assign rr_idx[k] = (sum >= (SW+1)'(NUM_SLV)) ? SW'(sum - (SW+1)'(NUM_SLV)) : sum[SW-1:0];
  end

  assign grant_inc = (grant == SW'(NUM_SLV - 1)) ? '0 : grant + SW'(1);

`ifdef ARB_URGENT_EN
  logic [NUM_SLV-1:0] urg;
  logic               pick_urg, urg_gnt;

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_urg
    assign urg[i] = &slv_mode[i];
  end

  // Descending scan so the slave closest to ptr is written last and wins;
  // the urgent pass runs second so it overrides any plain requester.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    pick_urg = 1'b0;
    for (int k = NUM_SLV - 1; k >= 0; k--)
      if (req[rr_idx[k]]) begin
        pick     = rr_idx[k];
        pick_vld = 1'b1;
      end
    for (int k = NUM_SLV - 1; k >= 0; k--)
      if (urg[rr_idx[k]]) begin
        pick     = rr_idx[k];
        pick_urg = 1'b1;
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                         urg_gnt <= 1'b0;
    else if (state == IDLE && !mstr_cmplt && pick_vld)  urg_gnt <= pick_urg;

  // Urgent grants run until mode drop or halt
  assign burst_end = xfer & (bcnt == BW'(BURST_MAX - 1)) & ~urg_gnt;
`else
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_SLV - 1; k >= 0; k--)
      if (req[rr_idx[k]]) begin
        pick     = rr_idx[k];
        pick_vld = 1'b1;
      end
  end

  assign burst_end = xfer & (bcnt == BW'(BURST_MAX - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next-state and arbitration bookkeeping
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    bcnt_nxt  = bcnt;
    if (xfer && bcnt != BW'(BURST_MAX)) bcnt_nxt = bcnt + BW'(1);
    case (state)
      IDLE:
        if (mstr_cmplt) state_nxt = HALT;
        else if (pick_vld) begin
          state_nxt = BUSY;
          grant_nxt = pick;
          bcnt_nxt  = '0;
        end
      BUSY:
        if (mstr_cmplt) state_nxt = HALT;
        else if (!req[grant] || burst_end) begin
          state_nxt = IDLE;
          ptr_nxt   = grant_inc;
        end
      HALT:
        // interrupted slave gets first shot on resume
        if (!mstr_cmplt) begin
          state_nxt = IDLE;
          ptr_nxt   = grant;
        end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb busy = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr   <= '0;
      grant <= '0;
      bcnt  <= '0;
    end else begin
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
      bcnt  <= bcnt_nxt;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slvx_data       <= '0;
      slvx_data_valid <= 1'b0;
      slvx_mode       <= '0;
      slvx_proc_val   <= '0;
      data_source     <= '0;
    end else begin
      slvx_data_valid <= xfer;
      if (xfer) begin
        slvx_data     <= slv_data[grant];
        slvx_mode     <= slv_mode[grant];
        slvx_proc_val <= slv_proc_val[grant];
        data_source   <= grant;
      end
    end

endmodule

// File: tb/tb_slv_arbiter_rr.sv
// tb_slv_arbiter_rr: directed scenarios for slv_arbiter_rr with a per-cycle behavioural model
// plus literal ready/sequence expectations. Honours ARB_URGENT_EN when defined.
module tb_slv_arbiter_rr;
  localparam int N = 4, DW = 32, PV_W = 8, MODE_W = 2, BM = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0][MODE_W-1:0] slv_mode = '0;
  logic [N-1:0]             slv_data_valid = '0;
  logic [N-1:0][DW-1:0]     slv_data = '0;
  logic [N-1:0][PV_W-1:0]   slv_proc_val = '0;
  logic [N-1:0]             slv_ready;
  logic                     fifo_full = 1'b0, mstr_cmplt = 1'b0;
  logic [DW-1:0]            slvx_data;
  logic                     slvx_data_valid;
  logic [MODE_W-1:0]        slvx_mode;
  logic [PV_W-1:0]          slvx_proc_val;
  logic [1:0]               data_source;

  int n_vec = 0, n_err = 0, cyc = 0;
  int src_log[$];

  slv_arbiter_rr #(.NUM_SLV(N), .DW(DW), .PV_W(PV_W), .MODE_W(MODE_W), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n), .slv_mode(slv_mode), .slv_data_valid(slv_data_valid),
    .slv_data(slv_data), .slv_proc_val(slv_proc_val), .slv_ready(slv_ready),
    .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt), .slvx_data(slvx_data),
    .slvx_data_valid(slvx_data_valid), .slvx_mode(slvx_mode), .slvx_proc_val(slvx_proc_val),
    .data_source(data_source));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: owner = slave currently holding the grant (-1 none); start_at = where the next search begins
  int owner = -1, last = 0, start_at = 0, done = 0;
  bit halted = 1'b0, urg_own = 1'b0;
  logic              e_valid = 1'b0;
  logic [DW-1:0]     e_data = '0;
  logic [MODE_W-1:0] e_mode = '0;
  logic [PV_W-1:0]   e_pv = '0;
  logic [1:0]        e_src = '0;

  function automatic int pick_next(input int from);
    int p = -1;
    for (int k = 0; k < N; k++)
      if (p < 0 && slv_mode[(from + k) % N] != '0) p = (from + k) % N;
`ifdef ARB_URGENT_EN
    for (int k = N - 1; k >= 0; k--)
      if (slv_mode[(from + k) % N] == '1) p = (from + k) % N;
`endif
    return p;
  endfunction

  always @(negedge clk) begin : cmp
    logic [N-1:0] er;
    logic x;
    int s;
    if (!rst_n) begin
      owner = -1; last = 0; start_at = 0; done = 0; halted = 1'b0; urg_own = 1'b0;
      e_valid = 1'b0; e_data = '0; e_mode = '0; e_pv = '0; e_src = '0;
    end else begin
      er = '0;
      if (owner >= 0 && !fifo_full && !mstr_cmplt && slv_mode[owner] != '0) er[owner] = 1'b1;
      chk("ready", 64'(slv_ready), 64'(er));
      chk("out_valid", 64'(slvx_data_valid), 64'(e_valid));
      chk("out_data", 64'(slvx_data), 64'(e_data));
      chk("out_mode", 64'(slvx_mode), 64'(e_mode));
      chk("out_pv", 64'(slvx_proc_val), 64'(e_pv));
      chk("out_src", 64'(data_source), 64'(e_src));
      if (slvx_data_valid) src_log.push_back(int'(data_source));
      x = (owner >= 0) && er[owner] && slv_data_valid[owner];
      e_valid = x;
      if (x) begin
        e_data = slv_data[owner]; e_mode = slv_mode[owner];
        e_pv = slv_proc_val[owner]; e_src = 2'(owner);
      end
      if (mstr_cmplt) begin
        halted = 1'b1; owner = -1;
      end else if (halted) begin
        halted = 1'b0; start_at = last;
      end else if (owner < 0) begin
        s = pick_next(start_at);
        if (s >= 0) begin
          owner = s; last = s; done = 0;
          urg_own = 1'b0;
`ifdef ARB_URGENT_EN
          urg_own = (slv_mode[s] == '1);
`endif
        end
      end else if (slv_mode[owner] == '0) begin
        start_at = (owner + 1) % N; owner = -1;
      end else if (x) begin
        done++;
        if (done == BM && !urg_own) begin
          start_at = (owner + 1) % N; owner = -1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      slv_data[i]     = {8'(i), 24'(cyc)};
      slv_proc_val[i] = 8'(16 * i + cyc);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic drive(input int s, input logic [MODE_W-1:0] m, input logic v);
    slv_mode[s] = m;
    slv_data_valid[s] = v;
  endtask

  task automatic clear_all();
    slv_mode = '0;
    slv_data_valid = '0;
  endtask

  task automatic rdy(input string nm, input logic [N-1:0] e);
    #1;
    chk(nm, 64'(slv_ready), 64'(e));
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_ready"}, 64'(slv_ready), 64'd0);
    chk({nm, "_valid"}, 64'(slvx_data_valid), 64'd0);
    chk({nm, "_data"}, 64'(slvx_data), 64'd0);
    chk({nm, "_mode"}, 64'(slvx_mode), 64'd0);
    chk({nm, "_pv"}, 64'(slvx_proc_val), 64'd0);
    chk({nm, "_src"}, 64'(data_source), 64'd0);
  endtask

  initial begin
    int base;
    int exp_seq[13];
    exp_seq = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0, 2};

    // Reset with idle inputs
    steps(2);
    chk_zero_outs("rst");
    rst_n = 1'b1;
    steps(2);
    chk_zero_outs("post_rst");

    // Slaves 0 and 2 streaming: bursts of BM with one bubble between grants
    drive(0, 2'b01, 1'b1);
    drive(2, 2'b01, 1'b1);
    base = src_log.size();
    steps(20);
    chk("rr_len_ok", 64'(src_log.size() - base >= 13), 64'd1);
    if (src_log.size() - base >= 13)
      for (int i = 0; i < 13; i++) chk("rr_seq", 64'(src_log[base + i]), 64'(exp_seq[i]));
    clear_all();
    steps(3);

    // fifo_full mid-burst freezes ready without consuming burst budget
    drive(1, 2'b01, 1'b1);
    step(); rdy("ff_pre", 4'b0010);
    step(); rdy("ff_pre", 4'b0010);
    for (int i = 0; i < 3; i++) begin
      step(); fifo_full = 1'b1; rdy("ff_hold", 4'b0000);
    end
    step(); fifo_full = 1'b0; rdy("ff_resume", 4'b0010);
    step(); rdy("ff_last", 4'b0010);
    step(); rdy("ff_bubble", 4'b0000);
    step(); rdy("ff_regrant", 4'b0010);
    clear_all();
    steps(3);

    // mstr_cmplt pulse while slave 3 holds the grant; slave 3 re-wins
    drive(3, 2'b01, 1'b1);
    step(); drive(0, 2'b01, 1'b1); rdy("halt_pre", 4'b1000);
    step(); mstr_cmplt = 1'b1; rdy("halt_drop", 4'b0000);
    step(); rdy("halt_hold", 4'b0000);
    step(); mstr_cmplt = 1'b0; rdy("halt_exit", 4'b0000);
    step(); rdy("halt_idle", 4'b0000);
    step(); rdy("halt_regrant", 4'b1000);
    clear_all();
    steps(3);

    // Slave 2 drops mode on its 2nd transfer; next grant wraps to slave 0
    drive(2, 2'b01, 1'b1);
    step(); drive(0, 2'b01, 1'b1); rdy("drop_pre", 4'b0100);
    step(); drive(2, 2'b00, 1'b1); rdy("drop_now", 4'b0000);
    step(); rdy("drop_idle", 4'b0000);
    chk("drop_no_xfer", 64'(slvx_data_valid), 64'd0);
    step(); rdy("drop_next", 4'b0001);
    clear_all();
    steps(3);

    // Asynchronous reset mid-stream
    drive(1, 2'b01, 1'b1);
    steps(2);
    rst_n = 1'b0;
    #1;
    chk_zero_outs("mid_rst");
    clear_all();
    steps(2);
    rst_n = 1'b1;
    steps(2);

    // Slave 0 at mode 01, slave 3 at mode 11, ptr = 0
    drive(0, 2'b01, 1'b1);
    drive(3, 2'b11, 1'b1);
`ifdef ARB_URGENT_EN
    for (int i = 0; i < 7; i++) begin
      step(); rdy("urg_hold", 4'b1000);
    end
    step(); drive(3, 2'b00, 1'b1); rdy("urg_drop", 4'b0000);
    step(); rdy("urg_idle", 4'b0000);
    step(); rdy("urg_next", 4'b0001);
`else
    step(); rdy("mode_blind_first", 4'b0001);
    steps(3);
    step(); rdy("mode_blind_bubble", 4'b0000);
    step(); rdy("mode_blind_next", 4'b1000);
`endif
    clear_all();
    steps(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
